// File: rtl/postop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : postop_pkg
// Description : Shared state, mode and channel encodings for the post-op
//               vital-sign display path.
// Revision    : 1.0 - initial release
// ============================================================================
package postop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIVE = 2'd1,
        HIST = 2'd2
    } state_t;

    localparam logic MODE_LIVE = 1'b0;
    localparam logic MODE_HIST = 1'b1;

    localparam logic CH_HR   = 1'b0;
    localparam logic CH_TEMP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vital_history_viewer_if.sv
`default_nettype none
// ============================================================================
// Module      : vital_history_viewer_if
// Description : Keypad pulses, sample stream and display word of the viewer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vital_history_viewer_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          postop;
    logic          tasto_status;
    logic          tasto_hist;
    logic          tasto_change;
    logic          sample_valid;
    logic          sample_ch;
    logic [DW-1:0] sample_data;
    logic          disp_valid;
    logic          disp_mode;
    logic          disp_ch;
    logic [AW-1:0] disp_idx;
    logic [DW-1:0] disp_data;

    modport master (
        output postop, tasto_status, tasto_hist, tasto_change,
        output sample_valid, sample_ch, sample_data,
        input  disp_valid, disp_mode, disp_ch, disp_idx, disp_data
    );

    modport slave (
        input  postop, tasto_status, tasto_hist, tasto_change,
        input  sample_valid, sample_ch, sample_data,
        output disp_valid, disp_mode, disp_ch, disp_idx, disp_data
    );

endinterface
`default_nettype wire

// File: rtl/vital_ring.sv
`default_nettype none
// ============================================================================
// Module      : vital_ring
// Description : Per-channel circular sample history with saturating count
//               and a combinational read port addressed by age (0 = newest).
// Revision    : 1.0 - initial release
// ============================================================================
module vital_ring #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_wr_en,
    input  wire logic [DW-1:0] i_wr_data,
    input  wire logic [AW-1:0] i_age,
    output logic      [DW-1:0] o_rdata,
    output logic      [AW:0]   o_count
);

    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_addr;

    // Storage is not reset: count gates whether any entry is meaningful.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_count != c_FULL) begin
                r_count <= r_count + (AW+1)'(1);
            end
        end
    end

    assign w_rd_addr = r_wr_ptr - AW'(1) - i_age;
    assign o_rdata   = r_mem[w_rd_addr];
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/vital_history_viewer.sv
`default_nettype none
// ============================================================================
// Module      : vital_history_viewer
// Description : Live / history browser over two vital-sign channels with a
//               registered display word.
// Revision    : 1.0 - initial release
// ============================================================================
module vital_history_viewer
    import postop_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    vital_history_viewer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state, w_state_nxt;
    logic          r_sel_ch, w_sel_ch_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;

    logic [DW-1:0] w_rdata_hr, w_rdata_temp, w_rdata_sel;
    logic [AW:0]   w_count_hr, w_count_temp, w_count_sel;
    logic          w_valid;

    logic          r_disp_valid, r_disp_mode, r_disp_ch;
    logic [AW-1:0] r_disp_idx;
    logic [DW-1:0] r_disp_data;

    vital_ring #(.DW(DW), .DEPTH(DEPTH)) u_ring_hr (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.sample_valid && (bus.sample_ch == CH_HR)),
        .i_wr_data (bus.sample_data),
        .i_age     (r_idx),
        .o_rdata   (w_rdata_hr),
        .o_count   (w_count_hr)
    );

    vital_ring #(.DW(DW), .DEPTH(DEPTH)) u_ring_temp (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.sample_valid && (bus.sample_ch == CH_TEMP)),
        .i_wr_data (bus.sample_data),
        .i_age     (r_idx),
        .o_rdata   (w_rdata_temp),
        .o_count   (w_count_temp)
    );

    assign w_rdata_sel = (r_sel_ch == CH_TEMP) ? w_rdata_temp : w_rdata_hr;
    assign w_count_sel = (r_sel_ch == CH_TEMP) ? w_count_temp : w_count_hr;
    assign w_valid     = (r_state != IDLE) && (w_count_sel != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sel_ch <= CH_HR;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel_ch <= w_sel_ch_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    // Only the highest-priority pulse acts: status > change > hist.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_ch_nxt = r_sel_ch;
        w_idx_nxt    = r_idx;
        if (!bus.postop) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = LIVE;
                    w_idx_nxt   = '0;
                end
                LIVE, HIST: begin
                    if (bus.tasto_status) begin
                        w_state_nxt = LIVE;
                        w_idx_nxt   = '0;
                    end else if (bus.tasto_change) begin
                        w_sel_ch_nxt = ~r_sel_ch;
                        w_idx_nxt    = '0;
                    end else if (bus.tasto_hist) begin
                        if (r_state == LIVE) begin
                            w_state_nxt = HIST;
                            w_idx_nxt   = '0;
                        end else if ({1'b0, r_idx} == (w_count_sel - (AW+1)'(1))) begin
                            w_idx_nxt = '0;
                        end else begin
                            w_idx_nxt = r_idx + AW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_valid <= 1'b0;
            r_disp_mode  <= MODE_LIVE;
            r_disp_ch    <= CH_HR;
            r_disp_idx   <= '0;
            r_disp_data  <= '0;
        end else begin
            r_disp_valid <= w_valid;
            r_disp_mode  <= (r_state == HIST) ? MODE_HIST : MODE_LIVE;
            r_disp_ch    <= r_sel_ch;
            r_disp_idx   <= r_idx;
            r_disp_data  <= w_valid ? w_rdata_sel : '0;
        end
    end

    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_mode  = r_disp_mode;
    assign bus.disp_ch    = r_disp_ch;
    assign bus.disp_idx   = r_disp_idx;
    assign bus.disp_data  = r_disp_data;

endmodule
`default_nettype wire

// File: doc/vital_history_viewer.md
# vital_history_viewer

Downstream consumer of the doctor keypad stage: it takes the single-cycle `tasto_status`, `tasto_hist` and `tasto_change` pulses and the `postop` level, and drives a registered display word. It stores the most recent vital-sign samples for two channels, channel 0 being heart rate and channel 1 temperature, each in its own circular buffer. It presents either the live (newest) value or a browsable history of the selected channel.

## Interface
- `DW`, 8, sample data width.
- `DEPTH`, 8, history entries per channel; a power of two, at least 2.
- `AW`, $clog2(DEPTH), index width (derived; do not override).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `postop`  in  1  post-op monitoring enabled (level).
- `tasto_status`  in  1  one-cycle pulse: show live value.
- `tasto_hist`  in  1  one-cycle pulse: enter or step history.
- `tasto_change`  in  1  one-cycle pulse: toggle the displayed channel.
- `sample_valid`  in  1  a sample is present this cycle.
- `sample_ch`  in  1  channel of the sample.
- `sample_data`  in  DW  sample value.
- `disp_valid`  out  1  `disp_data` is meaningful.
- `disp_mode`  out  1  0 = LIVE, 1 = HIST.
- `disp_ch`  out  1  channel shown.
- `disp_idx`  out  AW  age of the shown entry; 0 = newest.
- `disp_data`  out  DW  shown sample.

## Operation
- FSM states:
  - IDLE: entered whenever `postop`=0, from any state, overriding all pulses.
  - IDLE -> LIVE: on the first cycle with `postop`=1.
  - LIVE -> HIST: on `tasto_hist`; `idx` stays 0.
  - HIST + `tasto_hist`: `idx` advances to `idx`+1. When `idx` = count-1 it wraps to 0 instead.
  - HIST -> LIVE: on `tasto_status`; `idx` := 0.
- `tasto_change` in LIVE or HIST toggles `sel_ch`, sets `idx` := 0 and keeps the state.
- Pulse priority when several arrive in the same cycle: `tasto_status` > `tasto_change` > `tasto_hist`. Only the highest-priority pulse acts.
- Writes happen in every state, including IDLE:
  - `sample_valid` writes `sample_data` at `wr_ptr[sample_ch]`.
  - The pointer then increments modulo DEPTH.
  - `count[sample_ch]` saturates at DEPTH; once full, each write overwrites the oldest entry.
- Read address = (`wr_ptr[sel_ch]` - 1 - `idx`) mod DEPTH. All pointer arithmetic is AW bits with natural wrap.
- `idx` is always relative to the newest entry. A write to the selected channel while in HIST therefore shifts the displayed entry one step older. This is intended.
- `disp_valid` = 1 only when the state is not IDLE and `count[sel_ch]` > 0. When `disp_valid` = 0, `disp_data` = 0.
- Buffer contents and counts survive IDLE. Only `rst` clears them.

## Timing
- Reset values:
  - State IDLE; `sel_ch`=0; `idx`=0; pointers and counts 0.
  - `disp_valid`=0, `disp_mode`=0, `disp_ch`=0, `disp_idx`=0, `disp_data`=0.
- All outputs are registered. A pulse or sample at edge N is reflected on the outputs after edge N+1 (1-cycle latency).
- A sample written at edge N to the selected channel in LIVE appears on `disp_data` after edge N+1.
- Storage read is combinational from a register array. The output register provides the single cycle of latency.
- `postop` falling at edge N: `disp_valid`=0 after edge N+1.
- Reset asserted mid-operation: all state and outputs go to reset values immediately, without waiting for a clock edge.
- A write and a read of the same address in the same cycle return the old data to the output register. The new data appears one cycle later.

## Structure
- Shared package `postop_pkg` holds:
  - the state enum (IDLE, LIVE, HIST);
  - the mode constants MODE_LIVE=0 and MODE_HIST=1;
  - the channel constants CH_HR=0 and CH_TEMP=1.
- Sub-module `vital_ring` (parameters DW, DEPTH):
  - Contains the write pointer, saturating count, register array and a combinational read-by-age port (`age` in, `rdata`/`count` out).
  - Instantiated twice, once per channel.
- The top level holds the FSM, the channel select, `idx` and the output registers.

## Test plan
- Reset/empty: release `rst` with `postop`=1 and no samples. Required: state LIVE, `disp_valid`=0, `disp_data`=0.
- Live update: write ch0 = 72 then 75. Required: `disp_data`=75, `disp_idx`=0, `disp_valid`=1, each appearing one cycle after its write.
- History wrap: write ch0 = 10,11,…,19 (10 samples, DEPTH 8), then pulse `tasto_hist` 9 times. Required sequence of (`disp_idx`, `disp_data`): (0,19), (1,18), …, (7,12), (0,19). The value 11 never appears.
- Change and priority: in HIST at `idx`=3, pulse `tasto_change` and `tasto_hist` in the same cycle. Required: `disp_ch`=1, `disp_idx`=0, state HIST. Then pulse `tasto_status` and `tasto_change` in the same cycle. Required: LIVE, `disp_ch` unchanged.
- IDLE retention: drop `postop` and write ch1 = 37 while IDLE. Required: `disp_valid`=0. Re-raise `postop`. Required: LIVE, `disp_data`=37 if ch1 is selected.
- Async reset mid-HIST: assert `rst` between clock edges. Required: all outputs 0 immediately. After release, counts are 0 and `disp_valid`=0.
